// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program loader: the frame header codes the host
// sends, the loader state encoding and the write-target selector.
package program_loader_pkg;

  // Frame header codes
  localparam logic [7:0] LOAD_I = 8'hA0;
  localparam logic [7:0] LOAD_D = 8'hA1;
  localparam logic [7:0] RUN    = 8'hA5;
  localparam logic [7:0] HALT   = 8'hA6;

  // Loader states; every transition is taken on an accepted byte
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CSUM,
    RUNNING
  } state_t;

  // Which memory a load frame targets
  typedef enum logic {
    IMEM,
    DMEM
  } target_t;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if
// Byte-stream handshake between the host link and the loader.
//   in_data  : stream byte
//   in_valid : in_data valid
//   in_ready : loader can accept; a byte transfers when in_valid && in_ready
// master = host side (drives data/valid), slave = loader side (drives ready).
interface program_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/program_loader.sv
// program_loader
// Accepts framed bytes from the host link, writes payloads into the CPU's
// instruction or data memory and checks an 8-bit checksum per frame. The CPU
// is held in reset until a RUN arrives with no outstanding load error.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   host         : byte stream (in_data / in_valid / in_ready)
//   mem_addr     : write address (wraps mod 2^ADDR_W)
//   mem_wdata    : write data
//   imem_we      : one-cycle write strobe, instruction memory
//   dmem_we      : one-cycle write strobe, data memory
//   cpu_reset    : active-high reset to the CPU
//   busy         : a load frame is in progress
//   err_header   : sticky, unknown header byte seen
//   err_checksum : sticky, frame checksum mismatch
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   host,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              imem_we,
  output logic              dmem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err_header,
  output logic              err_checksum
);

  state_t            state;
  state_t            state_nxt;
  target_t           target;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        remaining;
  logic [7:0]        sum;
  logic              accept;
  logic [7:0]        din;

  assign accept = host.in_valid && host.in_ready;
  assign din    = host.in_data;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the outputs that follow directly from the state.
  // The CPU runs only while in RUNNING, so cpu_reset falls on the edge that
  // accepts RUN and rises on the edge that accepts HALT.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    cpu_reset = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          if (din == LOAD_I || din == LOAD_D) begin
            state_nxt = ADDR;
          end else if (din == RUN && !err_header && !err_checksum) begin
            state_nxt = RUNNING;
          end
        end
      end
      ADDR: begin
        busy = 1'b1;
        if (accept) state_nxt = LEN;
      end
      LEN: begin
        busy = 1'b1;
        if (accept) state_nxt = (din == 8'h00) ? CSUM : DATA;
      end
      DATA: begin
        busy = 1'b1;
        if (accept && remaining == 8'd1) state_nxt = CSUM;
      end
      CSUM: begin
        busy = 1'b1;
        if (accept) state_nxt = IDLE;
      end
      RUNNING: begin
        cpu_reset = 1'b0;
        if (accept && din == HALT) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: frame counters, running checksum, registered write port and
  // sticky error flags. The write strobes are single-cycle pulses, while
  // mem_addr/mem_wdata simply hold their last written values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host.in_ready <= 1'b0;
      target        <= IMEM;
      wr_addr       <= '0;
      remaining     <= 8'd0;
      sum           <= 8'd0;
      mem_addr      <= '0;
      mem_wdata     <= 8'd0;
      imem_we       <= 1'b0;
      dmem_we       <= 1'b0;
      err_header    <= 1'b0;
      err_checksum  <= 1'b0;
    end else begin
      host.in_ready <= 1'b1;
      imem_we       <= 1'b0;
      dmem_we       <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (din == LOAD_I || din == LOAD_D) begin
              target <= (din == LOAD_I) ? IMEM : DMEM;
              sum    <= din;
            end else if (din != RUN && din != HALT) begin
              err_header <= 1'b1;
            end
          end
          ADDR: begin
            wr_addr <= ADDR_W'(din);
            sum     <= sum + din;
          end
          LEN: begin
            remaining <= din;
            sum       <= sum + din;
          end
          DATA: begin
            mem_addr  <= wr_addr;
            mem_wdata <= din;
            imem_we   <= (target == IMEM);
            dmem_we   <= (target == DMEM);
            wr_addr   <= wr_addr + ADDR_W'(1);
            remaining <= remaining - 8'd1;
            sum       <= sum + din;
          end
          CSUM: begin
            // Writes already issued stay in memory even when this fails
            if (8'(sum + din) != 8'h00) err_checksum <= 1'b1;
            sum <= 8'd0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Self-checking bench for program_loader: a table of hand-computed vectors
// for an instruction load followed by run/halt, directed frame sequences for
// the corner cases, and randomized frames compared against a frame-level
// reference model.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       imem_we;
  logic       dmem_we;
  logic       cpu_reset;
  logic       busy;
  logic       err_header;
  logic       err_checksum;

  program_loader_if host_if ();

  program_loader #(.ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .host         (host_if),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .imem_we      (imem_we),
    .dmem_we      (dmem_we),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .err_header   (err_header),
    .err_checksum (err_checksum)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: keeps the bytes of the frame in progress and decides
  // everything from the frame contents seen so far.
  bit         m_running;
  bit         m_eh;
  bit         m_ec;
  logic [7:0] m_frame[$];
  bit         m_wr_i;
  bit         m_wr_d;
  logic [7:0] m_wr_addr;
  logic [7:0] m_wr_data;

  function automatic void model_reset();
    m_running = 1'b0;
    m_eh      = 1'b0;
    m_ec      = 1'b0;
    m_frame.delete();
    m_wr_i    = 1'b0;
    m_wr_d    = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] b);
    int         n;
    int         len;
    logic [7:0] s;
    m_wr_i = 1'b0;
    m_wr_d = 1'b0;
    if (m_running) begin
      if (b == HALT) m_running = 1'b0;
    end else if (m_frame.size() == 0) begin
      if (b == LOAD_I || b == LOAD_D) m_frame.push_back(b);
      else if (b == RUN) begin
        if (!m_eh && !m_ec) m_running = 1'b1;
      end else if (b != HALT) m_eh = 1'b1;
    end else begin
      m_frame.push_back(b);
      n = m_frame.size();
      if (n >= 3) begin
        len = int'(m_frame[2]);
        if (n > 3 && n <= 3 + len) begin
          m_wr_i    = (m_frame[0] == LOAD_I);
          m_wr_d    = (m_frame[0] == LOAD_D);
          m_wr_addr = m_frame[1] + 8'(n - 4);
          m_wr_data = b;
        end else if (n == 4 + len) begin
          s = 8'h00;
          foreach (m_frame[i]) s = s + m_frame[i];
          if (s != 8'h00) m_ec = 1'b1;
          m_frame.delete();
        end
      end
    end
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one byte slot from a negedge, let the active edge take it, and
  // return at the following negedge where outputs are sampled.
  task automatic applyStimulus(input logic [7:0] b, input bit v);
    host_if.in_data  = b;
    host_if.in_valid = v;
    @(posedge clk);
    if (v) model_step(b);
    else begin
      m_wr_i = 1'b0;
      m_wr_d = 1'b0;
    end
    @(negedge clk);
    host_if.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    compare({name, " status"},
            {25'd0, host_if.in_ready, cpu_reset, busy, err_header, err_checksum, imem_we, dmem_we},
            {25'd0, 1'b1, !m_running, m_frame.size() != 0, m_eh, m_ec, m_wr_i, m_wr_d});
    if (m_wr_i || m_wr_d)
      compare({name, " write"}, {16'd0, mem_addr, mem_wdata}, {16'd0, m_wr_addr, m_wr_data});
  endtask

  task automatic sendBytes(input string name, input bq_t bytes, input bit gapped);
    foreach (bytes[i]) begin
      applyStimulus(bytes[i], 1'b1);
      checkOutput(name);
      if (gapped) begin
        applyStimulus(8'($urandom), 1'b0);
        checkOutput({name, " gap"});
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    host_if.in_valid = 1'b0;
    #1;
    compare("reset state",
            {8'd0, host_if.in_ready, cpu_reset, busy, err_header, err_checksum, imem_we, dmem_we,
             mem_addr, mem_wdata, 1'b0},
            {8'd0, 7'b0100000, 8'h00, 8'h00, 1'b0});
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         valid;
    bit         exp_iwe;
    bit         exp_dwe;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;
    bit         exp_cpu_reset;
    bit         exp_busy;
    bit         exp_eh;
    bit         exp_ec;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] d, input bit v, input bit iwe, input logic [7:0] a,
                              input logic [7:0] w, input bit cr, input bit bz);
    vec_t t;
    t.data = d; t.valid = v; t.exp_iwe = iwe; t.exp_dwe = 1'b0;
    t.exp_addr = a; t.exp_wdata = w; t.exp_cpu_reset = cr; t.exp_busy = bz;
    t.exp_eh = 1'b0; t.exp_ec = 1'b0;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[$];
    bq_t        bytes;
    logic [7:0] s;
    logic [7:0] hdr;
    int         len;
    int         r;

    host_if.in_data  = 8'h00;
    host_if.in_valid = 1'b0;
    model_reset();

    // Instruction load, then RUN, a discarded byte and HALT
    vecs.push_back(mk(8'hA0, 1, 0, 8'h00, 8'h00, 1, 1));
    vecs.push_back(mk(8'h00, 1, 0, 8'h00, 8'h00, 1, 1));
    vecs.push_back(mk(8'h04, 1, 0, 8'h00, 8'h00, 1, 1));
    vecs.push_back(mk(8'h44, 1, 1, 8'h00, 8'h44, 1, 1));
    vecs.push_back(mk(8'h48, 1, 1, 8'h01, 8'h48, 1, 1));
    vecs.push_back(mk(8'h26, 1, 1, 8'h02, 8'h26, 1, 1));
    vecs.push_back(mk(8'h53, 1, 1, 8'h03, 8'h53, 1, 1));
    vecs.push_back(mk(8'h57, 1, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(8'hA5, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(8'hA5, 1, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(8'h12, 1, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(8'hA6, 1, 0, 8'h00, 8'h00, 1, 0));

    doReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].valid);
      compare($sformatf("table[%0d] status", i),
              {26'd0, cpu_reset, busy, err_header, err_checksum, imem_we, dmem_we},
              {26'd0, vecs[i].exp_cpu_reset, vecs[i].exp_busy, vecs[i].exp_eh, vecs[i].exp_ec,
               vecs[i].exp_iwe, vecs[i].exp_dwe});
      if (vecs[i].exp_iwe || vecs[i].exp_dwe)
        compare($sformatf("table[%0d] write", i), {16'd0, mem_addr, mem_wdata},
                {16'd0, vecs[i].exp_addr, vecs[i].exp_wdata});
    end

    // Data load whose address wraps from 0xFF to 0x00
    sendBytes("wrap load", '{8'hA1, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h2B}, 1'b0);
    compare("wrap no csum error", {31'd0, err_checksum}, 32'd0);

    // Bad checksum: payload still written, RUN then refused
    sendBytes("bad csum", '{8'hA1, 8'h04, 8'h01, 8'h04, 8'h00}, 1'b0);
    compare("bad csum flag", {31'd0, err_checksum}, 32'd1);
    sendBytes("run after error", '{8'hA5}, 1'b0);
    compare("run refused", {31'd0, cpu_reset}, 32'd1);

    // Unknown header, then a zero-length frame after reset
    doReset();
    sendBytes("bad header", '{8'h3C}, 1'b0);
    compare("header flag", {31'd0, err_header}, 32'd1);
    doReset();
    sendBytes("zero length", '{8'hA0, 8'h10, 8'h00, 8'h50}, 1'b0);

    // Reset in the middle of a frame, then a clean reload and run
    sendBytes("partial frame", '{8'hA0, 8'h00, 8'h03, 8'h11}, 1'b0);
    doReset();
    sendBytes("reload", '{8'hA0, 8'h00, 8'h04, 8'h44, 8'h48, 8'h26, 8'h53, 8'h57, 8'hA5}, 1'b0);
    compare("reload running", {31'd0, cpu_reset}, 32'd0);
    sendBytes("halt", '{8'hA6}, 1'b0);

    // Same instruction frame with in_valid low every other cycle
    sendBytes("gapped load", '{8'hA0, 8'h00, 8'h04, 8'h44, 8'h48, 8'h26, 8'h53, 8'h57}, 1'b1);

    // Randomized frames and commands
    for (int f = 0; f < 150; f++) begin
      if (f % 15 == 0) doReset();
      r = $urandom_range(0, 9);
      bytes.delete();
      if (r < 5) begin
        hdr = (r % 2 == 0) ? LOAD_I : LOAD_D;
        len = $urandom_range(0, 6);
        bytes.push_back(hdr);
        bytes.push_back(8'($urandom));
        bytes.push_back(8'(len));
        for (int k = 0; k < len; k++) bytes.push_back(8'($urandom));
        s = 8'h00;
        foreach (bytes[k]) s = s + bytes[k];
        s = 8'h00 - s;
        if ($urandom_range(0, 3) == 0) s = s ^ 8'h01;
        bytes.push_back(s);
      end else if (r < 7) begin
        bytes.push_back(RUN);
      end else if (r == 7) begin
        bytes.push_back(HALT);
      end else begin
        for (int k = 0; k < r - 7; k++) bytes.push_back(8'($urandom));
      end
      sendBytes($sformatf("random[%0d]", f), bytes, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that sits directly upstream of the CPU. It accepts framed bytes from a host link, writes them into the CPU's instruction or data memory through write ports, and verifies an 8-bit checksum per frame. It holds the CPU in reset until a RUN command arrives with no outstanding load error. It replaces the hierarchical memory pokes the bench does today with a synthesizable load path.

## Interface
Parameters:
- ADDR_W, 8, memory address width; addresses wrap mod 2^ADDR_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept; a byte transfers when in_valid && in_ready
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- imem_we  out  1  one-cycle write strobe, instruction memory
- dmem_we  out  1  one-cycle write strobe, data memory
- cpu_reset  out  1  active-high reset to CPU; 1 = CPU held
- busy  out  1  frame in progress (state not IDLE/RUNNING)
- err_header  out  1  sticky: unknown header byte seen
- err_checksum  out  1  sticky: frame checksum mismatch

## Operation
- Headers (package constants):
  - 0xA0 = LOAD_I, 3-byte header then payload.
  - 0xA1 = LOAD_D, same format.
  - 0xA5 = RUN, single byte.
  - 0xA6 = HALT, single byte.
- Load frame: HDR, ADDR, LEN, LEN payload bytes, CSUM.
  - Valid when the 8-bit sum of every frame byte, including CSUM, is 0x00.
- States: IDLE, ADDR, LEN, DATA, CSUM, RUNNING. Every transition happens on an accepted byte.
- IDLE:
  - LOAD_I/LOAD_D: latch target, go to ADDR.
  - RUN with both error flags 0: go to RUNNING.
  - RUN with either error flag 1: ignored, stay IDLE.
  - HALT: no-op.
  - Any other byte: set err_header, stay IDLE.
- ADDR: latch start address (low ADDR_W bits), go to LEN.
- LEN: latch count.
  - count 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: each payload byte produces one write to the current address, then address = address+1 mod 2^ADDR_W. After the count-th byte, go to CSUM.
- CSUM: compare the running sum, then go to IDLE.
  - Mismatch sets err_checksum.
  - Writes already issued are not rolled back.
- RUNNING:
  - cpu_reset = 0.
  - HALT: cpu_reset = 1, go to IDLE.
  - All other bytes are accepted and discarded.
- Error flags clear only on reset.

## Timing
- Reset (asynchronous, reset = 0):
  - State = IDLE.
  - in_ready = 0, cpu_reset = 1.
  - imem_we = dmem_we = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, both error flags = 0.
  - The running sum is cleared.
- in_ready is 1 in every state after reset deasserts. The loader never back-pressures, so back-to-back bytes are allowed every cycle.
- Write latency: the payload byte is accepted at edge N. mem_addr, mem_wdata and the selected we are registered and valid for the cycle after edge N, and drop at N+1 unless another payload byte was accepted at N+1.
- cpu_reset:
  - Falls at the edge that accepts RUN.
  - Rises at the edge that accepts HALT.
- Reset mid-frame: the partial frame is abandoned and the CPU is re-held. Memory contents already written are untouched.
- in_valid low in any state: no state change, no strobes.

## Structure
- loader_pkg:
  - Header constants LOAD_I, LOAD_D, RUN, HALT.
  - State enum.
  - Target type (IMEM/DMEM).
- No sub-module. The checksum accumulator and the address/length counters are inline registers.

## Test plan
- Instruction load: stream A0 00 04 44 48 26 53 57, then A5.
  - Writes: imem_we at addr 0..3 with 0x44, 0x48, 0x26, 0x53.
  - No errors; cpu_reset falls on RUN.
- Data load with wrap: A1 FF 02 11 22 2B.
  - Writes: dmem_we at addr 0xFF = 0x11, then addr 0x00 = 0x22.
  - err_checksum stays 0.
- Bad checksum: A1 04 01 04 00 (correct CSUM is 0x56).
  - Writes: dmem[4] = 0x04 is written.
  - err_checksum = 1; a following A5 leaves cpu_reset = 1.
- Bad header and zero length:
  - 0x3C sets err_header.
  - After reset, A0 10 00 50: no writes, no error, returns to IDLE.
- Run/halt and reset mid-frame:
  - A5 then 0x12 (discarded) then A6: cpu_reset returns to 1.
  - A0 00 03 11 followed by reset pulse: state IDLE, cpu_reset = 1, errors 0.
  - A fresh A0 00 04 44 48 26 53 57 frame after that loads correctly.
- Gapped input: the first frame with in_valid toggling every other cycle gives identical writes, one per accepted payload byte.
